// File: rtl/beat_pkg.sv
// Shared types and width helpers for the beat detector.
// The helpers derive every internal width from the top-level parameters.
package beat_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    UPDATE = 2'd2
  } beat_state_t;

  // Magnitude drops the sign bit because the most negative code saturates.
  function automatic int mag_w(input int sample_w);
    return sample_w - 1;
  endfunction

  function automatic int acc_w(input int sample_w, input int window_log2);
    return sample_w - 1 + window_log2;
  endfunction

  function automatic int hsum_w(input int sample_w, input int history_log2);
    return sample_w - 1 + history_log2;
  endfunction

  function automatic int cmp_w(input int sample_w, input int history_log2);
    return sample_w - 1 + history_log2 + 8;
  endfunction

endpackage

// File: rtl/energy_history.sv
// Ring buffer of recent window energies with a running sum of its contents.
// oldest is the entry the next push overwrites.
module energy_history
  import beat_pkg::*;
#(
  parameter int SAMPLE_W     = 16,
  parameter int HISTORY_LOG2 = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  push,
  input  logic [mag_w(SAMPLE_W)-1:0]            din,
  output logic [mag_w(SAMPLE_W)-1:0]            oldest,
  output logic [hsum_w(SAMPLE_W,HISTORY_LOG2)-1:0] sum
);

  localparam int DATA_W = mag_w(SAMPLE_W);
  localparam int SUM_W  = hsum_w(SAMPLE_W, HISTORY_LOG2);
  localparam int DEPTH  = 2 ** HISTORY_LOG2;

  logic [DATA_W-1:0]       mem [DEPTH];
  logic [HISTORY_LOG2-1:0] wr_ptr;

  assign oldest = mem[wr_ptr];

  // NOTE: the history must start at zero so the running sum stays consistent
  // with its entries, so this small memory is reset rather than left as RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      sum    <= '0;
    end else if (push) begin
      mem[wr_ptr] <= din;
      wr_ptr      <= wr_ptr + HISTORY_LOG2'(1);
      sum         <= sum - SUM_W'(oldest) + SUM_W'(din);
    end
  end

endmodule

// File: rtl/beat_detector.sv
// Audio-energy beat detector: windowed mean |sample| compared against a running
// average of recent windows; emits a one-cycle beat_trigger after a spike.
module beat_detector
  import beat_pkg::*;
#(
  parameter int SAMPLE_W        = 16,
  parameter int WINDOW_LOG2     = 8,
  parameter int HISTORY_LOG2    = 3,
  parameter int THRESH_NUM      = 3,
  parameter int THRESH_DEN_LOG2 = 1,
  parameter int HOLDOFF_WINDOWS = 4,
  parameter int MIN_ENERGY      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SAMPLE_W-1:0]   sample_in,
  input  logic                  sample_valid,
  output logic                  beat_trigger,
  output logic [SAMPLE_W-2:0]   energy_out,
  output logic                  energy_valid
);

  localparam int MAG_BITS  = mag_w(SAMPLE_W);
  localparam int ACC_BITS  = acc_w(SAMPLE_W, WINDOW_LOG2);
  localparam int HSUM_BITS = hsum_w(SAMPLE_W, HISTORY_LOG2);
  localparam int CMP_BITS  = cmp_w(SAMPLE_W, HISTORY_LOG2);
  localparam int WARM_MAX  = 2 ** HISTORY_LOG2;
  localparam int WARM_BITS = HISTORY_LOG2 + 1;
  localparam int HOLD_BITS = $clog2(HOLDOFF_WINDOWS + 2);

  if (WINDOW_LOG2 < 2) begin : g_window_check
    $error("beat_detector: WINDOW_LOG2 must be at least 2");
  end

  logic [SAMPLE_W-1:0]    neg_sample;
  logic [MAG_BITS-1:0]    mag;
  logic [ACC_BITS-1:0]    acc;
  logic [ACC_BITS-1:0]    acc_next;
  logic [WINDOW_LOG2-1:0] cnt;
  logic                   window_done;
  logic [MAG_BITS-1:0]    energy;

  // NOTE: every branch assigns mag, so this block stays purely combinational.
  always_comb begin
    neg_sample = '0 - sample_in;
    mag        = sample_in[MAG_BITS-1:0];
    if (sample_in[SAMPLE_W-1]) begin
      if (sample_in[SAMPLE_W-2:0] == '0) mag = '1;
      else                               mag = neg_sample[MAG_BITS-1:0];
    end
  end

  assign acc_next    = acc + ACC_BITS'(mag);
  assign window_done = sample_valid && (cnt == '1);

  // NOTE: state updates use non-blocking assignments so every register sees
  // the pre-edge value of every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      cnt    <= '0;
      energy <= '0;
    end else if (sample_valid) begin
      cnt <= cnt + WINDOW_LOG2'(1);
      if (window_done) begin
        energy <= acc_next[ACC_BITS-1:WINDOW_LOG2];
        acc    <= '0;
      end else begin
        acc <= acc_next;
      end
    end
  end

  beat_state_t           state;
  logic                  push;
  logic [MAG_BITS-1:0]   oldest;
  logic [HSUM_BITS-1:0]  hist_sum;
  logic [MAG_BITS-1:0]   avg;
  logic [CMP_BITS-1:0]   lhs;
  logic [CMP_BITS-1:0]   rhs;
  logic [HOLD_BITS-1:0]  holdoff_cnt;
  logic [WARM_BITS-1:0]  warm_cnt;
  logic                  beat_cond;
  logic                  beat_dec;

  assign push = (state == UPDATE);

  energy_history #(
    .SAMPLE_W     (SAMPLE_W),
    .HISTORY_LOG2 (HISTORY_LOG2)
  ) u_history (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .din    (energy),
    .oldest (oldest),
    .sum    (hist_sum)
  );

  // The history still holds only earlier windows while in EVAL.
  assign avg = hist_sum[HSUM_BITS-1:HISTORY_LOG2];
  assign lhs = CMP_BITS'(energy) << THRESH_DEN_LOG2;
  assign rhs = CMP_BITS'(avg) * CMP_BITS'(THRESH_NUM);

  assign beat_cond = (lhs > rhs)
                   && (energy >= MAG_BITS'(MIN_ENERGY))
                   && (warm_cnt == WARM_BITS'(WARM_MAX))
                   && (holdoff_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      beat_dec     <= 1'b0;
      beat_trigger <= 1'b0;
      energy_valid <= 1'b0;
      energy_out   <= '0;
      holdoff_cnt  <= '0;
      warm_cnt     <= '0;
    end else begin
      beat_trigger <= 1'b0;
      energy_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (window_done) state <= EVAL;
        end
        EVAL: begin
          beat_dec <= beat_cond;
          state    <= UPDATE;
        end
        UPDATE: begin
          beat_trigger <= beat_dec;
          energy_valid <= 1'b1;
          energy_out   <= energy;
          if (beat_dec)                holdoff_cnt <= HOLD_BITS'(HOLDOFF_WINDOWS);
          else if (holdoff_cnt != '0)  holdoff_cnt <= holdoff_cnt - HOLD_BITS'(1);
          if (warm_cnt != WARM_BITS'(WARM_MAX)) warm_cnt <= warm_cnt + WARM_BITS'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beat_detector.sv
// Directed bench for beat_detector with the small test configuration:
// 4-sample windows, 4-window history, ratio 3/2, holdoff 2, energy floor 16.
module tb_beat_detector;

  logic        clk;
  logic        reset;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        beat_trigger;
  logic [14:0] energy_out;
  logic        energy_valid;

  int vectors;
  int miscompares;

  logic b2b_on;
  int   obs_q[$];

  beat_detector #(
    .SAMPLE_W        (16),
    .WINDOW_LOG2     (2),
    .HISTORY_LOG2    (2),
    .THRESH_NUM      (3),
    .THRESH_DEN_LOG2 (1),
    .HOLDOFF_WINDOWS (2),
    .MIN_ENERGY      (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .beat_trigger (beat_trigger),
    .energy_out   (energy_out),
    .energy_valid (energy_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (b2b_on && energy_valid) obs_q.push_back(int'(energy_out));
  end

  function automatic int tb_mag(input logic [15:0] s);
    logic [15:0] n;
    n = 16'h0 - s;
    if (s == 16'h8000) return 32767;
    if (s[15]) return int'(n);
    return int'(s);
  endfunction

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // One window of +a,-a,+a,-a, then checks pulse timing and values.
  task automatic run_window(input logic [15:0] a, input int exp_e,
                            input logic exp_beat, input string tag);
    for (int i = 0; i < 4; i++) begin
      sample_in    = (i % 2 == 1) ? (16'h0 - a) : a;
      sample_valid = 1'b1;
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (energy_valid !== 1'b0 || beat_trigger !== 1'b0) begin
      miscompares++;
      $display("FAIL %s early_pulse: valid=%0b beat=%0b, want 0 0", tag, energy_valid, beat_trigger);
    end
    @(posedge clk); #1;
    vectors++;
    if (energy_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s energy_valid: got %0b want 1", tag, energy_valid);
    end
    vectors++;
    if (int'(energy_out) !== exp_e) begin
      miscompares++;
      $display("FAIL %s energy_out: got %0d want %0d", tag, energy_out, exp_e);
    end
    vectors++;
    if (beat_trigger !== exp_beat) begin
      miscompares++;
      $display("FAIL %s beat_trigger: got %0b want %0b", tag, beat_trigger, exp_beat);
    end
    @(posedge clk); #1;
    vectors++;
    if (energy_valid !== 1'b0 || beat_trigger !== 1'b0) begin
      miscompares++;
      $display("FAIL %s pulse_width: valid=%0b beat=%0b, want 0 0", tag, energy_valid, beat_trigger);
    end
  endtask

  task automatic test_reset();
    int seen;
    @(posedge clk); #1;
    vectors++;
    if (energy_valid !== 1'b0 || beat_trigger !== 1'b0 || energy_out !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%0b beat=%0b energy=%0d, want 0 0 0", energy_valid, beat_trigger, energy_out);
    end
    reset = 1'b0;
    // A full window, then reset while its pulse is high.
    for (int i = 0; i < 4; i++) begin
      sample_in = 16'd500; sample_valid = 1'b1;
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++;
    if (energy_valid !== 1'b1 || energy_out !== 15'd500) begin
      miscompares++;
      $display("FAIL pre_reset_pulse: valid=%0b energy=%0d, want 1 500", energy_valid, energy_out);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (energy_valid !== 1'b0 || beat_trigger !== 1'b0 || energy_out !== 15'd0) begin
      miscompares++;
      $display("FAIL async_reset: valid=%0b beat=%0b energy=%0d, want 0 0 0", energy_valid, beat_trigger, energy_out);
    end
    reset = 1'b0;
    // Reset while the evaluation is in flight must produce no pulse.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      sample_in = 16'd700; sample_valid = 1'b1;
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
    reset = 1'b1; #1; reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (energy_valid === 1'b1) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_eval: got %0d pulses want 0", seen);
    end
    // Partial window of large samples, discarded by reset.
    for (int i = 0; i < 2; i++) begin
      sample_in = 16'd5000; sample_valid = 1'b1;
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
    reset = 1'b1; #1; reset = 1'b0;
    for (int w = 0; w < 4; w++) run_window(16'd1000, 1000, 1'b0, $sformatf("warmup%0d", w));
  endtask

  task automatic test_steady();
    for (int w = 0; w < 8; w++) run_window(16'd100, 100, 1'b0, $sformatf("steady%0d", w));
  endtask

  task automatic test_spike();
    run_window(16'd200, 200, 1'b1, "spike");
    for (int w = 0; w < 4; w++) run_window(16'd100, 100, 1'b0, $sformatf("refill_a%0d", w));
    run_window(16'd140, 140, 1'b0, "below_ratio");
    for (int w = 0; w < 4; w++) run_window(16'd100, 100, 1'b0, $sformatf("refill_b%0d", w));
  endtask

  task automatic test_holdoff();
    run_window(16'd400, 400, 1'b1, "holdoff_w1");
    run_window(16'd400, 400, 1'b0, "holdoff_w2");
    run_window(16'd400, 400, 1'b0, "holdoff_w3");
    run_window(16'd400, 400, 1'b0, "holdoff_w4");
  endtask

  task automatic test_saturation_floor();
    run_window(16'h8000, 32767, 1'b1, "saturate");
    pulse_reset();
    for (int w = 0; w < 4; w++) run_window(16'd0, 0, 1'b0, $sformatf("zero_hist%0d", w));
    run_window(16'd10, 10, 1'b0, "below_floor");
    run_window(16'd20, 20, 1'b1, "floor_ok");
  endtask

  task automatic test_back_to_back();
    int exp_q[$];
    int sum;
    logic [15:0] s;
    pulse_reset();
    obs_q.delete();
    b2b_on = 1'b1;
    for (int w = 0; w < 40; w++) begin
      sum = 0;
      for (int i = 0; i < 4; i++) begin
        s = 16'($urandom);
        sample_in    = s;
        sample_valid = 1'b1;
        sum += tb_mag(s);
        @(posedge clk); #1;
      end
      exp_q.push_back(sum >> 2);
    end
    sample_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    b2b_on = 1'b0;
    vectors++;
    if (obs_q.size() !== 40) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d windows want 40", obs_q.size());
    end
    for (int w = 0; w < 40; w++) begin
      vectors++;
      if (w >= obs_q.size()) begin
        miscompares++;
        $display("FAIL b2b_energy%0d: got none want %0d", w, exp_q[w]);
      end else if (obs_q[w] !== exp_q[w]) begin
        miscompares++;
        $display("FAIL b2b_energy%0d: got %0d want %0d", w, obs_q[w], exp_q[w]);
      end
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    b2b_on       = 1'b0;
    reset        = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    test_reset();
    test_steady();
    test_spike();
    test_holdoff();
    test_saturation_floor();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
